// File: rtl/tpu_tile_sequencer.sv
// Command-driven sequencer for a 4x4 MAC tile with ping-pong A/B banks and a C store buffer.
// Optional build macro TPU_SEQ_PERF_EN adds a saturating MAC-cycle counter on perf_cycles.
module tpu_tile_sequencer #(
    parameter int ADDR_BITS = 16,
    parameter int K_MAX     = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           funct,
    input  logic [31:0]          input0,
    input  logic [31:0]          input1,
    output logic                 ld_bank,
    output logic                 rd_bank,
    output logic [ADDR_BITS-1:0] rd_idx,
    output logic                 mac_clr,
    output logic                 mac_en,
    output logic                 c_wr_en,
    output logic [1:0]           c_row,
    output logic [ADDR_BITS-1:0] c_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef TPU_SEQ_PERF_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    localparam logic [2:0]  F_CONFIG = 3'd1;
    localparam logic [2:0]  F_START  = 3'd6;
    localparam logic [2:0]  F_CLEAR  = 3'd4;
    localparam logic [15:0] K_MAX_W  = 16'(K_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_STORE = 3'd4
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_full;
    logic                   r_ld_bank;
    logic                   r_rd_bank;
    logic [ADDR_BITS-1:0]   r_rd_idx;
    logic                   r_mac_clr;
    logic                   r_mac_en;
    logic                   r_c_wr_en;
    logic [1:0]             r_c_row;
    logic [ADDR_BITS-1:0]   r_c_idx;
    logic                   r_done;
    logic                   r_err;
    logic [15:0]            r_k;
    logic [15:0]            r_kcnt;
    logic [ADDR_BITS-1:0]   r_base;
    logic [ADDR_BITS-1:0]   r_tile;

    logic                   w_cmd_ready;
    logic                   w_acc;
    logic                   w_cfg;
    logic                   w_cfg_bad;
    logic                   w_start;
    logic                   w_start_ok;
    logic                   w_clear;
    logic                   w_release;
    logic [1:0]             w_rel_mask;
    logic [1:0]             w_set_mask;
    logic [1:0]             w_full_nxt;
    logic                   w_rd_bank_nxt;
    logic                   w_unused;

    // Command acceptance: CONFIG only while fully idle, START only into an empty load bank.
    always_comb begin
        w_cmd_ready = 1'b1;
        case (funct)
            F_CONFIG: w_cmd_ready = (r_state == S_IDLE) && (r_full == 2'b00);
            F_START:  w_cmd_ready = ~r_full[r_ld_bank];
            default:  w_cmd_ready = 1'b1;
        endcase
    end

    assign w_acc      = cmd_valid & w_cmd_ready;
    assign w_cfg      = w_acc & (funct == F_CONFIG);
    assign w_cfg_bad  = (input0[15:0] == 16'd0) || (input0[15:0] > K_MAX_W);
    assign w_start    = w_acc & (funct == F_START);
    assign w_start_ok = w_start & (r_k != 16'd0);
    assign w_clear    = w_acc & (funct == F_CLEAR);

    // Release and a new load may coincide; both masks apply to the same next-state vector.
    assign w_release     = (r_state == S_STORE) && (r_c_row == 2'd3);
    assign w_rel_mask    = w_release  ? (2'b01 << r_rd_bank) : 2'b00;
    assign w_set_mask    = w_start_ok ? (2'b01 << r_ld_bank) : 2'b00;
    assign w_full_nxt    = (r_full & ~w_rel_mask) | w_set_mask;
    assign w_rd_bank_nxt = w_release ? ~r_rd_bank : r_rd_bank;

    assign w_unused = ^{input0[31:16], input1[31:ADDR_BITS]};

    // Main tile FSM together with bank bookkeeping and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_full    <= 2'b00;
            r_ld_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_idx  <= '0;
            r_mac_clr <= 1'b0;
            r_mac_en  <= 1'b0;
            r_c_wr_en <= 1'b0;
            r_c_row   <= 2'd0;
            r_c_idx   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_k       <= 16'd0;
            r_kcnt    <= 16'd0;
            r_base    <= '0;
            r_tile    <= '0;
        end else if (w_clear) begin
            r_state   <= S_IDLE;
            r_full    <= 2'b00;
            r_ld_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_mac_clr <= 1'b0;
            r_mac_en  <= 1'b0;
            r_c_wr_en <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_full    <= w_full_nxt;
            r_ld_bank <= r_ld_bank ^ w_start_ok;
            r_rd_bank <= w_rd_bank_nxt;
            r_mac_clr <= 1'b0;
            r_mac_en  <= (r_state == S_MAC);
            r_c_wr_en <= 1'b0;
            r_done    <= 1'b0;

            if (w_cfg) begin
                if (w_cfg_bad) begin
                    r_err <= 1'b1;
                end else begin
                    r_k    <= input0[15:0];
                    r_base <= input1[ADDR_BITS-1:0];
                    r_tile <= '0;
                end
            end else if (w_start && !w_start_ok) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_full_nxt[r_rd_bank]) begin
                        r_state   <= S_CLR;
                        r_mac_clr <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CLR: begin
                    r_state  <= S_MAC;
                    r_kcnt   <= 16'd0;
                    r_rd_idx <= '0;
                end
                S_MAC: begin
                    if (r_kcnt == (r_k - 16'd1)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_kcnt   <= r_kcnt + 16'd1;
                        r_rd_idx <= ADDR_BITS'(r_kcnt + 16'd1);
                    end
                end
                S_DRAIN: begin
                    r_state   <= S_STORE;
                    r_c_wr_en <= 1'b1;
                    r_c_row   <= 2'd0;
                    r_c_idx   <= r_base + {r_tile[ADDR_BITS-3:0], 2'b00};
                end
                S_STORE: begin
                    if (r_c_row == 2'd3) begin
                        r_done <= 1'b1;
                        r_tile <= r_tile + ADDR_BITS'(1);
                        if (w_full_nxt[w_rd_bank_nxt]) begin
                            r_state   <= S_CLR;
                            r_mac_clr <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_c_wr_en <= 1'b1;
                        r_c_row   <= r_c_row + 2'd1;
                        r_c_idx   <= r_c_idx + ADDR_BITS'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TPU_SEQ_PERF_EN
    logic [31:0] r_perf;

    // Saturating count of MAC cycles, restarted by every accepted valid CONFIG.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= 32'd0;
        end else if (w_cfg && !w_cfg_bad) begin
            r_perf <= 32'd0;
        end else if ((r_state == S_MAC) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end else begin
            r_perf <= r_perf;
        end
    end

    assign perf_cycles = r_perf;
`endif

    assign cmd_ready = w_cmd_ready;
    assign ld_bank   = r_ld_bank;
    assign rd_bank   = r_rd_bank;
    assign rd_idx    = r_rd_idx;
    assign mac_clr   = r_mac_clr;
    assign mac_en    = r_mac_en;
    assign c_wr_en   = r_c_wr_en;
    assign c_row     = r_c_row;
    assign c_idx     = r_c_idx;
    assign busy      = (r_state != S_IDLE) || (r_full != 2'b00);
    assign done      = r_done;
    assign err       = r_err;

endmodule
